cond_seed_loader: RTL
=====================

COND_SEED_LOADER -- requirements
Module: cond_seed_loader

Interface
REQ-001 Parameter COND_WIDTH, default 384, width of one conditioned word popped from the OHT output queue.
REQ-002 Parameter KEY_WIDTH, default 256, key slice width; V slice is COND_WIDTH-KEY_WIDTH (default 128).
REQ-003 Parameter RESEED_LIMIT, default 1024, number of AES blocks generated per seed before a reseed is mandatory.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state changes on posedge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cond_in  input  COND_WIDTH  head word of OHT output queue, valid whenever fifo_empty=0 (first-word fall-through).
REQ-008 fifo_empty  input  1  OHT output queue empty flag.
REQ-009 deque  output  1  single-cycle pop strobe to OHT output queue.
REQ-010 seed_key  output  KEY_WIDTH  cond_in[KEY_WIDTH-1:0] of captured word.
REQ-011 seed_v  output  COND_WIDTH-KEY_WIDTH  cond_in[COND_WIDTH-1:KEY_WIDTH] of captured word.
REQ-012 seed_valid  output  1  seed_key/seed_v valid toward AES core.
REQ-013 seed_ready  input  1  AES core accepts seed when high with seed_valid.
REQ-014 gen_done  input  1  one-cycle pulse per AES block produced.
REQ-015 force_reseed  input  1  request immediate reseed (SPI/debug).
REQ-016 reseed_req  output  1  high while waiting for a new seed.
REQ-017 blk_cnt  output  16  AES blocks produced under current seed.

Function
REQ-018 FSM states: WAIT, PRESENT, RUN; reset state WAIT.
REQ-019 WAIT: reseed_req=1; when fifo_empty=0, deque=1 combinationally that cycle, cond_in captured into seed regs at that edge, next state PRESENT.
REQ-020 WAIT with fifo_empty=1: deque=0, remain WAIT; deque SHALL never assert when fifo_empty=1 or outside WAIT.
REQ-021 At most one deque per seed; exactly one pop per WAIT->PRESENT transition.
REQ-022 PRESENT: seed_valid=1, seed_key/seed_v SHALL hold stable until seed_ready=1 sampled.
REQ-023 PRESENT with seed_ready=1: next state RUN, seed_key/seed_v zeroized next cycle, blk_cnt cleared to 0.
REQ-024 RUN: seed_valid=0, reseed_req=0; each gen_done increments blk_cnt by 1.
REQ-025 RUN: when blk_cnt+gen_done reaches RESEED_LIMIT, or force_reseed=1, next state WAIT.
REQ-026 gen_done and force_reseed same cycle: increment counted, then transition to WAIT.
REQ-027 blk_cnt saturates at 16'hFFFF, never wraps; holds value in WAIT/PRESENT until next seed acceptance.
REQ-028 gen_done outside RUN ignored; force_reseed outside RUN ignored (already reseeding).
REQ-029 Latency: fifo_empty falling in WAIT at cycle t -> deque at t -> seed_valid at t+1.
REQ-030 Seed word used verbatim; no bit reordering beyond the fixed key/V slicing.

Reset
REQ-031 On rst assertion, immediately: state WAIT, deque=0, seed_valid=0, seed_key=0, seed_v=0, blk_cnt=0, reseed_req=1.
REQ-032 Reset mid-PRESENT discards captured seed; no extra deque until reset released and fifo_empty=0.
REQ-033 First deque after reset release occurs no earlier than first posedge with rst=0.

Verification
REQ-034 Reset then fifo_empty=0, cond_in=384'h{A..} -> deque pulse 1 cycle, next cycle seed_valid=1, seed_key=cond_in[255:0], seed_v=cond_in[383:256].
REQ-035 Hold seed_ready=0 for 10 cycles in PRESENT -> seed_valid and data stable, deque=0 throughout; seed_ready=1 -> RUN, seeds read 0 next cycle.
REQ-036 RESEED_LIMIT=4, 4 gen_done pulses in RUN -> blk_cnt=4, state WAIT, reseed_req=1; second word popped only when fifo_empty=0.
REQ-037 force_reseed with gen_done same cycle at blk_cnt=2 -> blk_cnt=3, WAIT next cycle.
REQ-038 fifo_empty=1 held 50 cycles in WAIT -> deque never asserts, seed_valid=0.
REQ-039 Async rst asserted mid-PRESENT between clock edges -> seed_valid, seed_key, seed_v drop to 0 before next edge.

Source files
------------

// File: rtl/cond_seed_loader.sv
// Pops one conditioned word per seed, presents it to the AES core,
// then counts generated blocks until the next reseed is due.
module cond_seed_loader #(
  parameter int COND_WIDTH   = 384,
  parameter int KEY_WIDTH    = 256,
  parameter int RESEED_LIMIT = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COND_WIDTH-1:0]           cond_in,
  input  logic                            fifo_empty,
  output logic                            deque,
  output logic [KEY_WIDTH-1:0]            seed_key,
  output logic [COND_WIDTH-KEY_WIDTH-1:0] seed_v,
  output logic                            seed_valid,
  input  logic                            seed_ready,
  input  logic                            gen_done,
  input  logic                            force_reseed,
  output logic                            reseed_req,
  output logic [15:0]                     blk_cnt
);

  localparam int V_WIDTH = COND_WIDTH - KEY_WIDTH;
  localparam logic [31:0] LIMIT = RESEED_LIMIT;

  typedef enum logic [1:0] {
    S_WAIT,
    S_PRESENT,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [16:0] cnt_sum;
  logic [15:0] cnt_inc;
  logic        hit_limit;
  logic        accept;

  // Saturating increment; the limit is judged on the post-increment count.
  always_comb begin
    cnt_sum   = {1'b0, blk_cnt} + {16'd0, gen_done};
    cnt_inc   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    hit_limit = gen_done && ({15'd0, cnt_sum} >= LIMIT);
  end

  always_comb begin
    state_nxt = state;
    deque     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_WAIT: begin
        // rst gate keeps the pop strobe quiet while reset is held.
        if (!fifo_empty && !rst) begin
          deque     = 1'b1;
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (seed_ready) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (force_reseed || hit_limit)
          state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign seed_valid = (state == S_PRESENT);
  assign reseed_req = (state == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // Seed material is wiped as soon as the core has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_key <= '0;
      seed_v   <= '0;
    end else if (deque) begin
      seed_key <= cond_in[KEY_WIDTH-1:0];
      seed_v   <= cond_in[COND_WIDTH-1:KEY_WIDTH];
    end else if (accept) begin
      seed_key <= '0;
      seed_v   <= {V_WIDTH{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blk_cnt <= 16'd0;
    else if (accept)
      blk_cnt <= 16'd0;
    else if (state == S_RUN && gen_done)
      blk_cnt <= cnt_inc;
  end

endmodule
